// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered count/threshold flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              empty_q;
  logic              full_q;
  logic              af_q;
  logic              ae_q;
  logic              ov_q;
  logic              uf_q;
  logic              wr_ok;
  logic              rd_ok;

  // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
  always_comb begin
    rd_ok     = bus.rd_en & ~empty_q;
    wr_ok     = bus.wr_en & (~full_q | rd_ok);
    count_nxt = count_q;
    if (wr_ok && !rd_ok)
      count_nxt = count_q + CNT_W'(1);
    else if (rd_ok && !wr_ok)
      count_nxt = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst)
      mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      af_q    <= (count_nxt >= CNT_W'(AF_LEVEL));
      ae_q    <= (count_nxt <= CNT_W'(AE_LEVEL));
      ov_q    <= bus.wr_en & ~wr_ok;
      uf_q    <= bus.rd_en & ~rd_ok;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en only acknowledges/pops it.
  assign bus.data_out = mem[rd_ptr];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)
      dout_q <= '0;
    else if (rd_ok)
      dout_q <= mem[rd_ptr];
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = uf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=4, DEPTH=16, AF=14, AE=2); read data is
// checked by a scoreboard monitor fed from the stimulus process.
module tb_sync_fifo_param;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] exp_q [$];

  sync_fifo_param_if #(.DATA_W(4), .DEPTH(16)) bus ();

  sync_fifo_param #(
    .DATA_W  (4),
    .DEPTH   (16),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic r, input int d);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = 4'(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected word per accepted read and compares data_out when it is valid.
  always @(posedge clk) begin : monitor
    logic       acc;
    logic [3:0] exp_v;
    acc = bus.rd_en & ~bus.empty & ~rst;
    if (acc) begin
`ifndef SYNC_FIFO_FWFT_EN
      #1;
`endif
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_read: data_out=%0h with nothing expected at %0t", bus.data_out, $time);
      end else begin
        exp_v = exp_q.pop_front();
        chk("read_data", int'(bus.data_out), int'(exp_v));
      end
    end
  end

  initial begin : stim
    int w_seq;
    int r_seq;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;

    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_ae", int'(bus.almost_empty), 1);
    chk("rst_af", int'(bus.almost_full), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_unf", int'(bus.underflow), 0);
    chk("rst_dout", int'(bus.data_out), 0);

    // 1: fill with 0..15
    for (int i = 0; i < 16; i++) begin
      step(1, 0, i);
      chk("fill_count", int'(bus.count), i + 1);
      chk("fill_empty", int'(bus.empty), 0);
      chk("fill_ae", int'(bus.almost_empty), int'(i + 1 <= 2));
      chk("fill_af", int'(bus.almost_full), int'(i + 1 >= 14));
      chk("fill_full", int'(bus.full), int'(i + 1 == 16));
    end

    // 2: overflow while full; 4'hA must be dropped
    step(1, 0, 10);
    chk("ovf_pulse", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.count), 16);
    chk("ovf_full", int'(bus.full), 1);
    step(0, 0, 0);
    chk("ovf_clear", int'(bus.overflow), 0);

    // 3: drain 0..15, then underflow
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'(i));
      step(0, 1, 0);
      chk("drain_count", int'(bus.count), 15 - i);
      chk("drain_empty", int'(bus.empty), int'(i == 15));
      chk("drain_unf", int'(bus.underflow), 0);
    end
    step(0, 1, 0);
    chk("unf_pulse", int'(bus.underflow), 1);
    chk("unf_count", int'(bus.count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_hold", int'(bus.data_out), 15);
`endif
    step(0, 0, 0);
    chk("unf_clear", int'(bus.underflow), 0);

    // 4: wrap pointers, then 20 cycles of simultaneous read/write at count 8
    w_seq = 0;
    r_seq = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, w_seq);
      w_seq++;
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(4'(r_seq));
      r_seq++;
      step(0, 1, 0);
    end
    chk("wrap_empty", int'(bus.empty), 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, w_seq);
      w_seq++;
    end
    chk("wrap_count8", int'(bus.count), 8);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(4'(r_seq));
      r_seq++;
      step(1, 1, w_seq);
      w_seq++;
      chk("simul_count", int'(bus.count), 8);
      chk("simul_ovf", int'(bus.overflow), 0);
    end
    chk("simul_af", int'(bus.almost_full), 0);
    chk("simul_ae", int'(bus.almost_empty), 0);

    // 5: reset at count 5 with a write pending
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'(r_seq));
      r_seq++;
      step(0, 1, 0);
    end
    chk("pre_rst_count", int'(bus.count), 5);
    rst = 1'b1;
    step(1, 0, 9);
    rst = 1'b0;
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_ovf", int'(bus.overflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_dout", int'(bus.data_out), 0);
`endif
    step(1, 0, 5);
    chk("post_rst_count", int'(bus.count), 1);
    exp_q.push_back(4'h5);
    step(0, 1, 0);
    chk("post_rst_empty", int'(bus.empty), 1);
    step(0, 0, 0);

`ifdef SYNC_FIFO_FWFT_EN
    // 6: head word visible without rd_en
    step(1, 0, 3);
    chk("fwft_empty", int'(bus.empty), 0);
    chk("fwft_dout", int'(bus.data_out), 3);
    exp_q.push_back(4'h3);
    step(0, 1, 0);
    chk("fwft_pop_empty", int'(bus.empty), 1);
    chk("fwft_pop_count", int'(bus.count), 0);
`endif

    step(0, 0, 0);
    step(0, 0, 0);
    chk("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
